// File: rtl/niosoc_reset_pkg.sv
// Shared reset-sequencer definitions: FSM state encoding and parameter helpers.
package niosoc_reset_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_QUIESCE = 3'd1,
        S_ASSERT  = 3'd2,
        S_HOLD    = 3'd3,
        S_RELEASE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    function automatic int clamp_min(input int v, input int lo);
        return (v < lo) ? lo : v;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic int cnt_width(input int h, input int g, input int t);
        return $clog2(max3(h, g, t) + 1);
    endfunction

endpackage

// File: rtl/reset_sync_bit.sv
// Multi-flop synchronizer for a single level signal, cleared by the async system reset.
module reset_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_chain <= '0;
        else          r_chain <= {r_chain[STAGES-2:0], i_d};
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/soc_reset_sequencer.sv
// Software-requested, staged per-domain reset sequencer with automatic POR release.
// Optional pre-reset quiesce handshake enabled by defining RST_SEQ_QUIESCE_EN.
module soc_reset_sequencer
    import niosoc_reset_pkg::*;
#(
    parameter int N_DOMAINS   = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sw_reset_in,
    output logic [N_DOMAINS-1:0] dom_reset_n_out,
    output logic                 busy,
    output logic                 done_pulse
`ifdef RST_SEQ_QUIESCE_EN
    ,
    output logic                 quiesce_req,
    input  logic                 quiesce_ack,
    output logic                 timeout_flag
`endif
);

    localparam int HOLD_C = clamp_min(HOLD_CYCLES, 1);
    localparam int GAP_C  = clamp_min(STAGE_GAP, 1);
    localparam int SYNC_C = clamp_min(SYNC_STAGES, 2);
    localparam int ACK_C  = clamp_min(ACK_TIMEOUT, 1);
    localparam int CW     = cnt_width(HOLD_C, GAP_C, ACK_C);
    localparam int IW     = $clog2(N_DOMAINS) + 1;

    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_C - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(GAP_C - 1);
`ifdef RST_SEQ_QUIESCE_EN
    localparam logic [CW-1:0] ACK_LD  = CW'(ACK_C - 1);
`endif

    state_t                r_state, w_state_nxt;
    logic [CW-1:0]         r_cnt, w_cnt_nxt;
    logic [IW-1:0]         r_idx, w_idx_nxt;
    logic [N_DOMAINS-1:0]  r_dom, w_dom_nxt;
    logic                  w_sw_sync;
`ifdef RST_SEQ_QUIESCE_EN
    logic                  r_qreq, w_qreq_nxt;
    logic                  r_tflag, w_tflag_nxt;
`endif

    reset_sync_bit #(.STAGES(SYNC_C)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (sw_reset_in),
        .o_q     (w_sw_sync)
    );

    // POR lands in HOLD with the counter preloaded so the power-on release
    // gets the same full hold window as a software request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_HOLD;
            r_cnt   <= HOLD_LD;
            r_idx   <= '0;
            r_dom   <= '0;
`ifdef RST_SEQ_QUIESCE_EN
            r_qreq  <= 1'b0;
            r_tflag <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_dom   <= w_dom_nxt;
`ifdef RST_SEQ_QUIESCE_EN
            r_qreq  <= w_qreq_nxt;
            r_tflag <= w_tflag_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_dom_nxt   = r_dom;
`ifdef RST_SEQ_QUIESCE_EN
        w_qreq_nxt  = r_qreq;
        w_tflag_nxt = r_tflag;
`endif
        case (r_state)
            S_IDLE: begin
                w_dom_nxt = '1;
                if (w_sw_sync) begin
`ifdef RST_SEQ_QUIESCE_EN
                    w_state_nxt = S_QUIESCE;
                    w_cnt_nxt   = ACK_LD;
                    w_qreq_nxt  = 1'b1;
                    w_tflag_nxt = 1'b0;
`else
                    w_state_nxt = S_ASSERT;
                    w_dom_nxt   = '0;
`endif
                end
            end
`ifdef RST_SEQ_QUIESCE_EN
            S_QUIESCE: begin
                if (quiesce_ack || r_cnt == '0) begin
                    w_state_nxt = S_ASSERT;
                    w_dom_nxt   = '0;
                    w_qreq_nxt  = 1'b0;
                    if (!quiesce_ack) w_tflag_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
`endif
            S_ASSERT: begin
                w_dom_nxt   = '0;
                w_cnt_nxt   = HOLD_LD;
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                w_dom_nxt = '0;
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end else if (!w_sw_sync) begin
                    w_state_nxt = S_RELEASE;
                    w_dom_nxt   = N_DOMAINS'(1);
                    w_idx_nxt   = IW'(1);
                    w_cnt_nxt   = GAP_LD;
                end
            end
            // r_idx counts domains already released.
            S_RELEASE: begin
                if (w_sw_sync) begin
                    w_state_nxt = S_ASSERT;
                    w_dom_nxt   = '0;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end else if (r_idx < IW'(N_DOMAINS)) begin
                    w_dom_nxt = r_dom | (N_DOMAINS'(1) << r_idx);
                    w_idx_nxt = r_idx + IW'(1);
                    w_cnt_nxt = GAP_LD;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (w_sw_sync) begin
                    w_state_nxt = S_ASSERT;
                    w_dom_nxt   = '0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign dom_reset_n_out = r_dom;
    assign busy            = (r_state != S_IDLE);
    // An abandoned sequence never reports completion.
    assign done_pulse      = (r_state == S_DONE) && !w_sw_sync;
`ifdef RST_SEQ_QUIESCE_EN
    assign quiesce_req     = r_qreq;
    assign timeout_flag    = r_tflag;
`endif

endmodule

// File: tb/tb_soc_reset_sequencer.sv
// Scoreboarded bench for soc_reset_sequencer: expected output events are queued with the stimulus.
// Covers the quiesce handshake too when built with RST_SEQ_QUIESCE_EN.
module tb_soc_reset_sequencer;

    localparam int HOLD = 16;
    localparam int GAP  = 4;
`ifdef RST_SEQ_QUIESCE_EN
    localparam int QL   = 1;
`else
    localparam int QL   = 0;
`endif

    typedef struct {
        int         cyc;
        logic [2:0] dom;
        logic       done;
    } ev_t;

    logic       clk;
    logic       reset_n;
    logic       sw_reset_in;
    logic [2:0] dom;
    logic       busy;
    logic       done_pulse;
`ifdef RST_SEQ_QUIESCE_EN
    logic       quiesce_req;
    logic       quiesce_ack;
    logic       timeout_flag;
`endif

    int  cyc;
    int  checks;
    int  errors;
    ev_t exp_q[$];

    soc_reset_sequencer #(
        .N_DOMAINS   (3),
        .HOLD_CYCLES (HOLD),
        .STAGE_GAP   (GAP),
        .SYNC_STAGES (2),
        .ACK_TIMEOUT (255)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .sw_reset_in     (sw_reset_in),
        .dom_reset_n_out (dom),
        .busy            (busy),
        .done_pulse      (done_pulse)
`ifdef RST_SEQ_QUIESCE_EN
        ,
        .quiesce_req     (quiesce_req),
        .quiesce_ack     (quiesce_ack),
        .timeout_flag    (timeout_flag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_ev(input int c, input logic [2:0] d, input logic dn);
        ev_t e;
        e.cyc = c; e.dom = d; e.done = dn;
        exp_q.push_back(e);
    endtask

    task automatic push_release(input int r);
        push_ev(r,           3'b001, 1'b0);
        push_ev(r + GAP,     3'b011, 1'b0);
        push_ev(r + 2 * GAP, 3'b111, 1'b0);
        push_ev(r + 3 * GAP, 3'b111, 1'b1);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic end_check(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s pending: %0d expected events not seen, next cyc=%0d dom=%b",
                     name, exp_q.size(), exp_q[0].cyc, exp_q[0].dom);
            exp_q.delete();
        end
    endtask

    task automatic pulse_request();
        sw_reset_in = 1'b1;
        @(negedge clk);
        sw_reset_in = 1'b0;
    endtask

    task automatic test_reset();
        int c;
        @(negedge clk);
        checks++;
        if (dom !== 3'b000 || busy !== 1'b1 || done_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got dom=%b busy=%b done=%b want 000 1 0", dom, busy, done_pulse);
        end
`ifdef RST_SEQ_QUIESCE_EN
        checks++;
        if (quiesce_req !== 1'b0 || timeout_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_quiesce: got req=%b tflag=%b want 0 0", quiesce_req, timeout_flag);
        end
`endif
        c = cyc;
        push_release(c + HOLD);
        reset_n = 1'b1;
        wait_cyc(c + HOLD + 3 * GAP);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL por_busy_done: got busy=%b want 1", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || dom !== 3'b111) begin
            errors++;
            $display("FAIL por_idle: got busy=%b dom=%b want 0 111", busy, dom);
        end
        wait_cyc(cyc + 4);
        end_check("por");
    endtask

    task automatic test_short_request();
        int c, r;
        @(negedge clk);
        c = cyc;
        r = c + 3 + QL + 1 + HOLD;
        push_ev(c + 3 + QL, 3'b000, 1'b0);
        push_release(r);
        pulse_request();
        wait_cyc(r + 3 * GAP + 1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL short_idle: got busy=%b want 0", busy);
        end
        wait_cyc(cyc + 4);
        end_check("short_request");
    endtask

    task automatic test_long_request();
        int c;
        @(negedge clk);
        c = cyc;
        push_ev(c + 3 + QL, 3'b000, 1'b0);
        sw_reset_in = 1'b1;
        wait_cyc(c + 100);
        checks++;
        if (dom !== 3'b000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL long_held: got dom=%b busy=%b want 000 1", dom, busy);
        end
        push_release(c + 100 + 3);
        sw_reset_in = 1'b0;
        wait_cyc(c + 103 + 3 * GAP + 4);
        end_check("long_request");
    endtask

    task automatic test_rerequest();
        int c, r;
        @(negedge clk);
        c = cyc;
        r = c + 3 + QL + 1 + HOLD;
        push_ev(c + 3 + QL, 3'b000, 1'b0);
        push_ev(r, 3'b001, 1'b0);
        pulse_request();
        wait_cyc(r);
        push_ev(r + 3, 3'b000, 1'b0);
        push_release(r + 3 + 1 + HOLD);
        pulse_request();
        wait_cyc(r + 4 + HOLD + 3 * GAP + 4);
        end_check("rerequest");
    endtask

    task automatic test_midseq_reset();
        int c, r, k;
        @(negedge clk);
        c = cyc;
        r = c + 3 + QL + 1 + HOLD;
        push_ev(c + 3 + QL, 3'b000, 1'b0);
        push_ev(r, 3'b001, 1'b0);
        push_ev(r + GAP, 3'b011, 1'b0);
        pulse_request();
        wait_cyc(r + GAP + 1);
        @(posedge clk);
        #2;
        k = cyc;
        push_ev(k, 3'b000, 1'b0);
        reset_n = 1'b0;
        #1;
        checks++;
        if (dom !== 3'b000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: got dom=%b busy=%b want 000 1", dom, busy);
        end
        @(negedge clk);
        @(negedge clk);
        c = cyc;
        push_release(c + HOLD);
        reset_n = 1'b1;
        wait_cyc(c + HOLD + 3 * GAP + 4);
        end_check("midseq_reset");
    endtask

`ifdef RST_SEQ_QUIESCE_EN
    task automatic test_quiesce();
        int c;
        // ack arrives after five cycles of request
        @(negedge clk);
        quiesce_ack = 1'b0;
        c = cyc;
        push_ev(c + 8, 3'b000, 1'b0);
        push_release(c + 8 + 1 + HOLD);
        pulse_request();
        wait_cyc(c + 3);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (quiesce_req !== 1'b1 || dom !== 3'b111) begin
                errors++;
                $display("FAIL quiesce_req_high: cyc=%0d got req=%b dom=%b want 1 111", cyc, quiesce_req, dom);
            end
            if (i == 4) quiesce_ack = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (quiesce_req !== 1'b0 || timeout_flag !== 1'b0) begin
            errors++;
            $display("FAIL quiesce_ack_exit: got req=%b tflag=%b want 0 0", quiesce_req, timeout_flag);
        end
        quiesce_ack = 1'b0;
        wait_cyc(c + 9 + HOLD + 3 * GAP + 4);
        end_check("quiesce_ack");
        // no ack: timeout after 255 cycles
        c = cyc;
        push_ev(c + 258, 3'b000, 1'b0);
        push_release(c + 258 + 1 + HOLD);
        pulse_request();
        wait_cyc(c + 257);
        checks++;
        if (quiesce_req !== 1'b1 || timeout_flag !== 1'b0) begin
            errors++;
            $display("FAIL quiesce_wait: got req=%b tflag=%b want 1 0", quiesce_req, timeout_flag);
        end
        @(negedge clk);
        checks++;
        if (quiesce_req !== 1'b0 || timeout_flag !== 1'b1) begin
            errors++;
            $display("FAIL quiesce_timeout: got req=%b tflag=%b want 0 1", quiesce_req, timeout_flag);
        end
        wait_cyc(c + 259 + HOLD + 3 * GAP + 4);
        checks++;
        if (timeout_flag !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: got tflag=%b want 1", timeout_flag);
        end
        end_check("quiesce_timeout");
        // next request clears the flag
        quiesce_ack = 1'b1;
        c = cyc;
        push_ev(c + 4, 3'b000, 1'b0);
        push_release(c + 5 + HOLD);
        pulse_request();
        wait_cyc(c + 3);
        checks++;
        if (timeout_flag !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: got tflag=%b want 0", timeout_flag);
        end
        wait_cyc(c + 5 + HOLD + 3 * GAP + 4);
        end_check("quiesce_clear");
    endtask
`endif

    initial begin
        checks      = 0;
        errors      = 0;
        reset_n     = 1'b0;
        sw_reset_in = 1'b0;
`ifdef RST_SEQ_QUIESCE_EN
        quiesce_ack = 1'b1;
`endif
        fork
            begin : monitor
                logic [2:0] prev;
                ev_t        e;
                prev = 3'b000;
                forever begin
                    @(negedge clk);
                    if (dom !== prev || done_pulse === 1'b1) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_event: cyc=%0d dom=%b done=%b, nothing expected",
                                     cyc, dom, done_pulse);
                        end else begin
                            e = exp_q.pop_front();
                            if (e.cyc != cyc || e.dom !== dom || e.done !== done_pulse) begin
                                errors++;
                                $display("FAIL event: got cyc=%0d dom=%b done=%b want cyc=%0d dom=%b done=%b",
                                         cyc, dom, done_pulse, e.cyc, e.dom, e.done);
                            end
                        end
                    end
                    prev = dom;
                end
            end
        join_none

        test_reset();
        test_short_request();
        test_long_request();
        test_rerequest();
        test_midseq_reset();
`ifdef RST_SEQ_QUIESCE_EN
        test_quiesce();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
